// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants.
// Used by the modular-reduction path.
package kyber_pkg;

  localparam int KYBER_Q  = 3329;
  localparam int KYBER_N  = 256;
  localparam int COEF_WID = 12;
  localparam int Q_NEG    = (1 << (COEF_WID + 1)) - KYBER_Q;

endpackage

// File: rtl/cla_adder.sv
// Parallel-prefix carry-lookahead adder.
// Returns a WID+1 bit sum; the top bit is the carry out.
module cla_adder #(
  parameter int WID = 13
) (
  input  logic [WID-1:0] a_i,
  input  logic [WID-1:0] b_i,
  input  logic           cin_i,
  output logic [WID:0]   sum_o
);

  localparam int LVL = (WID > 1) ? $clog2(WID) : 1;

  logic [WID-1:0] hp;
  logic [WID-1:0] g;
  logic [WID-1:0] p;
  logic [WID-1:0] msk;

  // Prefix tree: g[i] becomes the carry out of bits i..0, cin folded in
  always_comb begin
    hp  = a_i ^ b_i;
    g   = (a_i & b_i) | {{(WID-1){1'b0}}, hp[0] & cin_i};
    p   = hp;
    msk = '0;
    for (int l = 0; l < LVL; l++) begin
      msk = '0;
      for (int j = 0; j < WID; j++) begin
        if (j < (1 << l)) msk[j] = 1'b1;
      end
      g = g | (p & (g << (1 << l)));
      p = p & ((p << (1 << l)) | msk);
    end
  end

  assign sum_o = {g[WID-1], hp ^ {g[WID-2:0], cin_i}};

endmodule

// File: rtl/mod_q_reduce.sv
// Two-stage streaming conditional subtract of Q.
// Optional sticky range flag: MODQ_RANGE_CHECK_EN.
module mod_q_reduce
  import kyber_pkg::*;
#(
  parameter int DATA_WID = COEF_WID,
  parameter int Q        = KYBER_Q,
  parameter int N_COEF   = KYBER_N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_WID:0]   in_sum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] out_coef,
  output logic                out_last,
  output logic                err_range
);

  localparam int IW = (N_COEF > 1) ? $clog2(N_COEF) : 1;
  localparam logic [DATA_WID:0] QN =
    (DATA_WID+1)'((1 << (DATA_WID + 1)) - Q);

  logic                s1_valid_q;
  logic [DATA_WID:0]   s1_sum_q;
  logic                s2_valid_q;
  logic [DATA_WID-1:0] s2_coef_q;
  logic [IW-1:0]       idx_q;
  logic                s1_adv;
  logic                s2_adv;
  logic [DATA_WID+1:0] add_sum;
  logic                c;
  logic [DATA_WID-1:0] t_lo;
  logic                unused_t_msb;
  logic [DATA_WID-1:0] coef_d;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  cla_adder #(
    .WID (DATA_WID + 1)
  ) u_cla (
    .a_i   (s1_sum_q),
    .b_i   (QN),
    .cin_i (1'b0),
    .sum_o (add_sum)
  );

  assign c            = add_sum[DATA_WID+1];
  assign t_lo         = add_sum[DATA_WID-1:0];
  assign unused_t_msb = add_sum[DATA_WID];
  assign coef_d       = c ? t_lo : s1_sum_q[DATA_WID-1:0];

  // Stage 1 captures the raw sum whenever it can move forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_sum_q <= in_sum;
    end
  end

  // Stage 2 holds the reduced coefficient until it is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_coef_q  <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_coef_q <= coef_d;
    end
  end

  // Position within the polynomial; wraps by power-of-two width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (s2_valid_q && out_ready) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_coef  = s2_coef_q;
  assign out_last  = s2_valid_q && (&idx_q);

`ifdef MODQ_RANGE_CHECK_EN
  localparam logic [DATA_WID+1:0] TWO_Q = (DATA_WID+2)'(2 * Q);

  logic in_fire;
  logic err_q;

  assign in_fire = in_valid && s1_adv;

  // Sticky flag for sums a single subtraction cannot fix
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (in_fire && ({1'b0, in_sum} >= TWO_Q)) begin
      err_q <= 1'b1;
    end
  end

  assign err_range = err_q;
`else
  assign err_range = 1'b0;
`endif

endmodule
